// File: rtl/mux_scan_sequencer.sv
// Address sequencer for the banked analog commutator chain: walks the bank slots,
// then a rotating aux slot and a terminator slot, with settle timing and a sample strobe.
module mux_scan_sequencer #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned GROUPS = 2,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned AUX_CNT = 3,
    parameter logic [AUX_CNT*SEL_W-1:0] AUX_CODES = 9'b110_100_011,
    parameter logic [SEL_W-1:0] TERM_CODE = 3'd5,
    parameter int unsigned SETTLE = 4,
    localparam int unsigned N = GROUPS * (2 ** ADDR_W),
    localparam int unsigned FRAME_LEN = N + 2,
    localparam int unsigned CH_W = $clog2(FRAME_LEN),
    localparam int unsigned AUX_W = (AUX_CNT > 1) ? $clog2(AUX_CNT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              switchSignal,
    input  logic              hold,
    output logic [ADDR_W-1:0] addrLow,
    output logic [SEL_W-1:0]  bankSel,
    output logic [CH_W-1:0]   cntChannel,
    output logic [AUX_W-1:0]  auxIndex,
    output logic              frameStart,
    output logic              sampleStrobe
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CH_W-1:0]  LAST_SLOT   = CH_W'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]  AUX_SLOT    = CH_W'(N);
    localparam logic [AUX_W-1:0] AUX_LAST    = AUX_W'(AUX_CNT - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT_LOW
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SEL_W-1:0]   bank_q, bank_d;
    logic [AUX_W-1:0]   aux_q, aux_d;
    logic               frame_q, frame_d;
    logic               strobe_q, strobe_d;
    logic [SET_W-1:0]   settle_q, settle_d;

    logic [CH_W-1:0]    slot_next;
    logic [SEL_W-1:0]   aux_code;

    // Aux table lookup for the entry that the next aux slot will use
    always_comb begin
        aux_code = '0;
        for (int unsigned i = 0; i < AUX_CNT; i++) begin
            if (aux_q == AUX_W'(i)) begin
                aux_code = AUX_CODES[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        slot_next = (cnt_q == LAST_SLOT) ? '0 : cnt_q + CH_W'(1);

        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        aux_d    = aux_q;
        frame_d  = 1'b0;
        strobe_d = 1'b0;
        settle_d = settle_q;

        case (state_q)
            ST_IDLE: begin
                // Index and address are decoded together so they never disagree
                if (switchSignal && !hold) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                    cnt_d    = slot_next;
                    frame_d  = (slot_next == '0);
                    if (slot_next < AUX_SLOT) begin
                        addr_d = slot_next[ADDR_W-1:0];
                        bank_d = SEL_W'(slot_next >> ADDR_W) + SEL_W'(1);
                    end else if (slot_next == AUX_SLOT) begin
                        addr_d = '0;
                        bank_d = aux_code;
                        aux_d  = (aux_q == AUX_LAST) ? '0 : aux_q + AUX_W'(1);
                    end else begin
                        addr_d = '0;
                        bank_d = TERM_CODE;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    strobe_d = 1'b1;
                    state_d  = ST_WAIT_LOW;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (!switchSignal) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset parks on the last slot so the first advance lands on slot 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= LAST_SLOT;
            addr_q   <= '0;
            bank_q   <= '0;
            aux_q    <= '0;
            frame_q  <= 1'b0;
            strobe_q <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            aux_q    <= aux_d;
            frame_q  <= frame_d;
            strobe_q <= strobe_d;
            settle_q <= settle_d;
        end
    end

    assign addrLow      = addr_q;
    assign bankSel      = bank_q;
    assign cntChannel   = cnt_q;
    assign auxIndex     = aux_q;
    assign frameStart   = frame_q;
    assign sampleStrobe = strobe_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: default geometry plus a small swept geometry.
module tb_mux_scan_sequencer;

    localparam int A_SETTLE = 4;
    localparam int A_N      = 16;
    localparam int A_FL     = 18;
    localparam int A_CPB    = 8;
    localparam int B_SETTLE = 1;
    localparam int B_N      = 12;
    localparam int B_FL     = 14;
    localparam int B_CPB    = 4;

    typedef struct {
        int cnt;
        int addr;
        int bank;
        int aux;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic sw_a, hold_a, fs_a, ss_a;
    logic [2:0] addr_a, bank_a;
    logic [4:0] cnt_a;
    logic [1:0] aux_a;
    logic sw_b, hold_b, fs_b, ss_b;
    logic [1:0] addr_b;
    logic [2:0] bank_b;
    logic [3:0] cnt_b;
    logic [0:0] aux_b;

    int n_checks = 0;
    int n_pass   = 0;
    int strobes_a = 0;
    int strobes_b = 0;
    int m_cnt_a, m_aux_a, m_cnt_b, m_aux_b;
    int aux_tab_a[3] = '{3, 4, 6};
    int aux_tab_b[1] = '{7};
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    mux_scan_sequencer dut_a (
        .clk(clk), .reset(reset), .switchSignal(sw_a), .hold(hold_a),
        .addrLow(addr_a), .bankSel(bank_a), .cntChannel(cnt_a),
        .auxIndex(aux_a), .frameStart(fs_a), .sampleStrobe(ss_a)
    );

    mux_scan_sequencer #(
        .ADDR_W(2), .GROUPS(3), .SETTLE(1), .AUX_CNT(1), .AUX_CODES(3'b111)
    ) dut_b (
        .clk(clk), .reset(reset), .switchSignal(sw_b), .hold(hold_b),
        .addrLow(addr_b), .bankSel(bank_b), .cntChannel(cnt_b),
        .auxIndex(aux_b), .frameStart(fs_b), .sampleStrobe(ss_b)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t model_next(input int cnt, input int aux, input int fl,
                                        input int n, input int cpb, input int aux_cnt,
                                        input int aux_code);
        exp_t e;
        e.cnt  = (cnt == fl - 1) ? 0 : cnt + 1;
        e.aux  = aux;
        e.addr = 0;
        if (e.cnt < n) begin
            e.addr = e.cnt % cpb;
            e.bank = e.cnt / cpb + 1;
        end else if (e.cnt == n) begin
            e.bank = aux_code;
            e.aux  = (aux + 1) % aux_cnt;
        end else begin
            e.bank = 5;
        end
        return e;
    endfunction

    // Slot contents are compared once the DUT signals the slot has settled
    always @(negedge clk) begin
        if (!reset && ss_a) begin
            exp_t e;
            strobes_a++;
            check_eq("a_sb_expected", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check_eq("a_sb_cnt", int'(cnt_a), e.cnt);
                check_eq("a_sb_addr", int'(addr_a), e.addr);
                check_eq("a_sb_bank", int'(bank_a), e.bank);
                check_eq("a_sb_aux", int'(aux_a), e.aux);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ss_b) begin
            exp_t e;
            strobes_b++;
            check_eq("b_sb_expected", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check_eq("b_sb_cnt", int'(cnt_b), e.cnt);
                check_eq("b_sb_addr", int'(addr_b), e.addr);
                check_eq("b_sb_bank", int'(bank_b), e.bank);
                check_eq("b_sb_aux", int'(aux_b), e.aux);
            end
        end
    end

    task automatic step_a();
        exp_t e;
        int lat;
        e = model_next(m_cnt_a, m_aux_a, A_FL, A_N, A_CPB, 3, aux_tab_a[m_aux_a]);
        if (e.cnt == A_N) check_eq("a_aux_pre", int'(aux_a), m_aux_a);
        q_a.push_back(e);
        m_cnt_a = e.cnt;
        m_aux_a = e.aux;
        sw_a = 1'b1;
        @(posedge clk); #1;
        sw_a = 1'b0;
        check_eq("a_cnt_edge", int'(cnt_a), e.cnt);
        check_eq("a_frame_start", int'(fs_a), int'(e.cnt == 0));
        lat = 0;
        while (!ss_a && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("a_strobe_lat", lat, A_SETTLE);
        @(posedge clk); #1;
        check_eq("a_strobe_width", int'(ss_a), 0);
        @(negedge clk);
    endtask

    task automatic step_b();
        exp_t e;
        int lat;
        e = model_next(m_cnt_b, m_aux_b, B_FL, B_N, B_CPB, 1, aux_tab_b[m_aux_b]);
        q_b.push_back(e);
        m_cnt_b = e.cnt;
        m_aux_b = e.aux;
        sw_b = 1'b1;
        @(posedge clk); #1;
        sw_b = 1'b0;
        check_eq("b_cnt_edge", int'(cnt_b), e.cnt);
        check_eq("b_frame_start", int'(fs_b), int'(e.cnt == 0));
        lat = 0;
        while (!ss_b && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("b_strobe_lat", lat, B_SETTLE);
        @(posedge clk); #1;
        check_eq("b_strobe_width", int'(ss_b), 0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int base;
        int s;
        reset = 1'b1;
        sw_a = 1'b0; hold_a = 1'b0; sw_b = 1'b0; hold_b = 1'b0;
        m_cnt_a = A_FL - 1; m_aux_a = 0;
        m_cnt_b = B_FL - 1; m_aux_b = 0;
        repeat (3) @(negedge clk);
        check_eq("a_rst_cnt", int'(cnt_a), A_FL - 1);
        check_eq("a_rst_addr", int'(addr_a), 0);
        check_eq("a_rst_bank", int'(bank_a), 0);
        check_eq("a_rst_aux", int'(aux_a), 0);
        check_eq("a_rst_fs", int'(fs_a), 0);
        check_eq("a_rst_ss", int'(ss_a), 0);
        check_eq("b_rst_cnt", int'(cnt_b), B_FL - 1);
        check_eq("b_rst_bank", int'(bank_b), 0);
        reset = 1'b0;
        @(negedge clk);

        // Four frames plus one slot: exercises every slot and the aux rotation wrap
        repeat (A_FL * 4 + 1) step_a();

        // Request during hold is dropped
        base = strobes_a;
        hold_a = 1'b1; sw_a = 1'b1;
        repeat (2) @(negedge clk);
        sw_a = 1'b0; hold_a = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("hold_no_adv", int'(cnt_a), m_cnt_a);
        check_eq("hold_no_strobe", strobes_a - base, 0);

        // Request held high advances once hold drops
        base = strobes_a;
        hold_a = 1'b1; sw_a = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("hold_high_no_adv", int'(cnt_a), m_cnt_a);
        e = model_next(m_cnt_a, m_aux_a, A_FL, A_N, A_CPB, 3, aux_tab_a[m_aux_a]);
        q_a.push_back(e);
        m_cnt_a = e.cnt; m_aux_a = e.aux;
        hold_a = 1'b0;
        @(posedge clk); #1;
        check_eq("hold_drop_adv", int'(cnt_a), e.cnt);
        repeat (A_SETTLE + 2) @(negedge clk);
        sw_a = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("hold_drop_strobes", strobes_a - base, 1);

        // Long level request gives exactly one advance
        base = strobes_a;
        e = model_next(m_cnt_a, m_aux_a, A_FL, A_N, A_CPB, 3, aux_tab_a[m_aux_a]);
        q_a.push_back(e);
        m_cnt_a = e.cnt; m_aux_a = e.aux;
        sw_a = 1'b1;
        @(posedge clk); #1;
        check_eq("long_adv", int'(cnt_a), e.cnt);
        repeat (19) @(negedge clk);
        sw_a = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("long_one_adv", int'(cnt_a), e.cnt);
        check_eq("long_one_strobe", strobes_a - base, 1);

        // Reset two cycles into settling aborts the strobe
        base = strobes_a;
        s = (m_cnt_a == A_FL - 1) ? 0 : m_cnt_a + 1;
        sw_a = 1'b1;
        @(posedge clk); #1;
        sw_a = 1'b0;
        check_eq("abort_adv", int'(cnt_a), s);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_eq("abort_cnt", int'(cnt_a), A_FL - 1);
        check_eq("abort_bank", int'(bank_a), 0);
        check_eq("abort_addr", int'(addr_a), 0);
        check_eq("abort_ss", int'(ss_a), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_cnt_a = A_FL - 1; m_aux_a = 0;
        m_cnt_b = B_FL - 1; m_aux_b = 0;
        repeat (6) @(negedge clk);
        check_eq("abort_no_strobe", strobes_a - base, 0);
        step_a();

        // Swept geometry: two frames plus a wrap
        repeat (B_FL * 2 + 1) step_b();

        repeat (3) @(negedge clk);
        check_eq("a_sb_drain", q_a.size(), 0);
        check_eq("b_sb_drain", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
